// File: rtl/color_centroid_if.sv
// Pixel stream in, centroid result out.
// Master side drives pixels; slave side is the centroid block.
interface color_centroid_if #(
    parameter int COLOR_WIDTH = 10,
    parameter int DISP_WIDTH  = 11
);
    logic                   enable;
    logic                   pix_valid;
    logic [COLOR_WIDTH-1:0] r_in;
    logic [COLOR_WIDTH-1:0] g_in;
    logic [COLOR_WIDTH-1:0] b_in;
    logic [DISP_WIDTH-1:0]  x_pos;
    logic [DISP_WIDTH-1:0]  y_pos;
    logic                   frame_end;
    logic [DISP_WIDTH-1:0]  x_obj;
    logic [DISP_WIDTH-1:0]  y_obj;
    logic                   obj_found;
    logic                   obj_valid;
    logic                   busy;
    logic                   overrun;

    modport master (
        output enable, pix_valid, r_in, g_in, b_in,
        output x_pos, y_pos, frame_end,
        input  x_obj, y_obj, obj_found, obj_valid,
        input  busy, overrun
    );

    modport slave (
        input  enable, pix_valid, r_in, g_in, b_in,
        input  x_pos, y_pos, frame_end,
        output x_obj, y_obj, obj_found, obj_valid,
        output busy, overrun
    );
endinterface

// File: rtl/color_centroid.sv
// Colour-keyed pixel accumulator with per-frame centroid
// computed by one shared restoring divider (x then y).
module color_centroid #(
    parameter int                     COLOR_WIDTH = 10,
    parameter int                     DISP_WIDTH  = 11,
    parameter logic [COLOR_WIDTH-1:0] R_MIN       = 10'd600,
    parameter logic [COLOR_WIDTH-1:0] GB_MAX      = 10'd300,
    parameter int                     MIN_PIXELS  = 16,
    parameter int                     CNT_WIDTH   = 2*DISP_WIDTH,
    parameter int                     SUM_WIDTH   = 3*DISP_WIDTH
) (
    input logic        clk,
    input logic        aresetn,
    color_centroid_if.slave bus
);
    localparam int BW = $clog2(SUM_WIDTH);
    localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(MIN_PIXELS);
    localparam logic [BW-1:0] LAST_BIT = BW'(SUM_WIDTH-1);

    typedef enum logic [2:0] {
        IDLE, DIV_X, DIV_Y, UPDATE, REPORT_NONE
    } state_t;

    state_t                state;
    logic [SUM_WIDTH-1:0]  sum_x, sum_y, nx, ny;
    logic [CNT_WIDTH-1:0]  cnt, ncnt, div_d;
    logic [SUM_WIDTH-1:0]  snap_y, quo, rem;
    logic [SUM_WIDTH-1:0]  quo_nx, rem_nx, diff, div_ext;
    logic [SUM_WIDTH:0]    rem_sh;
    logic [DISP_WIDTH-1:0] qx;
    logic [BW-1:0]         bit_cnt;
    logic                  hit, q_bit, last;

    always_comb begin
        hit = bus.pix_valid && bus.enable
            && (bus.r_in > R_MIN)
            && (bus.g_in < GB_MAX)
            && (bus.b_in < GB_MAX);
        nx   = sum_x + (hit ? SUM_WIDTH'(bus.x_pos) : '0);
        ny   = sum_y + (hit ? SUM_WIDTH'(bus.y_pos) : '0);
        ncnt = cnt + (hit ? CNT_WIDTH'(1) : '0);
        // remainder stays below the divisor, so SUM_WIDTH bits suffice
        div_ext = SUM_WIDTH'(div_d);
        rem_sh  = {rem, quo[SUM_WIDTH-1]};
        q_bit   = rem_sh >= {1'b0, div_ext};
        diff    = rem_sh[SUM_WIDTH-1:0] - div_ext;
        rem_nx  = q_bit ? diff : rem_sh[SUM_WIDTH-1:0];
        quo_nx  = {quo[SUM_WIDTH-2:0], q_bit};
        last    = bit_cnt == LAST_BIT;
    end

    // frame_end always restarts the accumulators, even on overrun
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else if (bus.frame_end) begin
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else begin
            sum_x <= nx;
            sum_y <= ny;
            cnt   <= ncnt;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            quo           <= '0;
            rem           <= '0;
            snap_y        <= '0;
            div_d         <= '0;
            qx            <= '0;
            bit_cnt       <= '0;
            bus.x_obj     <= '0;
            bus.y_obj     <= '0;
            bus.obj_found <= 1'b0;
            bus.obj_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.obj_valid <= 1'b0;
            bus.overrun   <= bus.frame_end && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (bus.frame_end) begin
                        if (ncnt < MIN_P) begin
                            state <= REPORT_NONE;
                        end else begin
                            quo      <= nx;
                            snap_y   <= ny;
                            div_d    <= ncnt;
                            rem      <= '0;
                            bit_cnt  <= '0;
                            bus.busy <= 1'b1;
                            state    <= DIV_X;
                        end
                    end
                end
                DIV_X: begin
                    quo     <= quo_nx;
                    rem     <= rem_nx;
                    bit_cnt <= bit_cnt + BW'(1);
                    if (last) begin
                        qx      <= quo_nx[DISP_WIDTH-1:0];
                        quo     <= snap_y;
                        rem     <= '0;
                        bit_cnt <= '0;
                        state   <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    quo     <= quo_nx;
                    rem     <= rem_nx;
                    bit_cnt <= bit_cnt + BW'(1);
                    if (last) state <= UPDATE;
                end
                UPDATE: begin
                    bus.x_obj     <= qx;
                    bus.y_obj     <= quo[DISP_WIDTH-1:0];
                    bus.obj_found <= 1'b1;
                    bus.obj_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                REPORT_NONE: begin
                    bus.obj_found <= 1'b0;
                    bus.obj_valid <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_color_centroid.sv
// Directed bench: two instances (MIN_PIXELS 16 and 1)
// share one stimulus stream.
module tb_color_centroid;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        en = 1'b1, pv = 1'b0, fe = 1'b0;
    logic [9:0]  r = '0, g = '0, b = '0;
    logic [10:0] x = '0, y = '0;
    int          vecs = 0, errs = 0;
    int          lat;

    always #5 clk = ~clk;

    color_centroid_if bus16 ();
    color_centroid_if bus1 ();

    assign bus16.enable = en;    assign bus1.enable = en;
    assign bus16.pix_valid = pv; assign bus1.pix_valid = pv;
    assign bus16.r_in = r;       assign bus1.r_in = r;
    assign bus16.g_in = g;       assign bus1.g_in = g;
    assign bus16.b_in = b;       assign bus1.b_in = b;
    assign bus16.x_pos = x;      assign bus1.x_pos = x;
    assign bus16.y_pos = y;      assign bus1.y_pos = y;
    assign bus16.frame_end = fe; assign bus1.frame_end = fe;

    color_centroid #(.MIN_PIXELS(16)) dut16 (
        .clk(clk), .aresetn(aresetn), .bus(bus16.slave));
    color_centroid #(.MIN_PIXELS(1)) dut1 (
        .clk(clk), .aresetn(aresetn), .bus(bus1.slave));

    task automatic send(input int px, input int py,
                        input int rr, input int gg,
                        input int bb, input bit f);
        pv = 1'b1; x = 11'(px); y = 11'(py);
        r = 10'(rr); g = 10'(gg); b = 10'(bb); fe = f;
        @(negedge clk);
        pv = 1'b0; fe = 1'b0;
    endtask

    task automatic fend();
        fe = 1'b1;
        @(negedge clk);
        fe = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, output int l);
        l = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (sel ? bus1.obj_valid : bus16.obj_valid) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic test_reset();
        #12;
        vecs++;
        if ({bus16.x_obj, bus16.y_obj, bus16.obj_found, bus16.obj_valid,
             bus16.busy, bus16.overrun} !== '0) begin
            errs++;
            $display("FAIL reset16 outputs not zero x=%0d y=%0d",
                     bus16.x_obj, bus16.y_obj);
        end
        vecs++;
        if ({bus1.x_obj, bus1.y_obj, bus1.obj_found, bus1.obj_valid,
             bus1.busy, bus1.overrun} !== '0) begin
            errs++;
            $display("FAIL reset1 outputs not zero x=%0d y=%0d",
                     bus1.x_obj, bus1.y_obj);
        end
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        send(100, 50, 1023, 0, 0, 1'b1);
        chk("single_busy", int'(bus1.busy), 1);
        wait_valid(1'b1, lat);
        chk("single_lat", lat, 67);
        chk("single_x", int'(bus1.x_obj), 100);
        chk("single_y", int'(bus1.y_obj), 50);
        chk("single_found", int'(bus1.obj_found), 1);
        @(negedge clk);
        chk("single_pulse", int'(bus1.obj_valid), 0);
        chk("single_busy_end", int'(bus1.busy), 0);
    endtask

    task automatic test_block();
        for (int yy = 300; yy < 310; yy++)
            for (int xx = 200; xx < 210; xx++)
                send(xx, yy, 1023, 100, 50, 1'b0);
        fend();
        wait_valid(1'b0, lat);
        chk("block_lat", lat, 67);
        chk("block_x", int'(bus16.x_obj), 204);
        chk("block_y", int'(bus16.y_obj), 304);
        chk("block_found", int'(bus16.obj_found), 1);
    endtask

    task automatic test_below();
        for (int i = 0; i < 15; i++) send(400 + i, 100, 1023, 0, 0, 1'b0);
        send(10, 10, 512, 512, 512, 1'b0);
        send(11, 10, 600, 0, 0, 1'b0);
        send(12, 10, 1023, 300, 0, 1'b0);
        send(13, 10, 1023, 0, 300, 1'b0);
        fend();
        wait_valid(1'b0, lat);
        chk("below_lat", lat, 1);
        chk("below_found", int'(bus16.obj_found), 0);
        chk("below_x_hold", int'(bus16.x_obj), 204);
        chk("below_y_hold", int'(bus16.y_obj), 304);
    endtask

    task automatic test_enable();
        en = 1'b0;
        for (int i = 0; i < 16; i++) send(10, 10, 1023, 0, 0, 1'b0);
        en = 1'b1;
        fend();
        wait_valid(1'b0, lat);
        chk("enable_lat", lat, 1);
        chk("enable_found", int'(bus16.obj_found), 0);
    endtask

    task automatic test_overlap();
        repeat (80) @(negedge clk);
        send(10, 10, 1023, 0, 0, 1'b0);
        send(0, 0, 1023, 0, 0, 1'b1);
        send(20, 30, 1023, 0, 0, 1'b0);
        send(40, 50, 1023, 0, 0, 1'b0);
        wait_valid(1'b1, lat);
        chk("overlap_lat", lat, 65);
        chk("overlap_x", int'(bus1.x_obj), 5);
        chk("overlap_y", int'(bus1.y_obj), 5);
        fend();
        wait_valid(1'b1, lat);
        chk("next_lat", lat, 67);
        chk("next_x", int'(bus1.x_obj), 30);
        chk("next_y", int'(bus1.y_obj), 40);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) send(10 + i, 5, 1023, 0, 0, 1'b0);
        fend();
        chk("ovr_busy", int'(bus16.busy), 1);
        for (int i = 0; i < 16; i++) send(100, 200, 1023, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        fend();
        chk("ovr_pulse", int'(bus16.overrun), 1);
        for (int i = 0; i < 16; i++) send(300, 400 + i, 1023, 0, 0, 1'b0);
        chk("ovr_single", int'(bus16.overrun), 0);
        wait_valid(1'b0, lat);
        chk("ovr_lat", lat, 31);
        chk("ovr_x", int'(bus16.x_obj), 17);
        chk("ovr_y", int'(bus16.y_obj), 5);
        fend();
        wait_valid(1'b0, lat);
        chk("ovr3_lat", lat, 67);
        chk("ovr3_x", int'(bus16.x_obj), 300);
        chk("ovr3_y", int'(bus16.y_obj), 407);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) send(50, 60, 1023, 0, 0, 1'b0);
        fend();
        repeat (31) @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("rst_x", int'(bus16.x_obj), 0);
        chk("rst_y", int'(bus16.y_obj), 0);
        chk("rst_found", int'(bus16.obj_found), 0);
        chk("rst_busy", int'(bus16.busy), 0);
        @(negedge clk);
        aresetn = 1'b1;
        wait_valid(1'b0, lat);
        chk("rst_no_valid", lat, -1);
        for (int i = 0; i < 16; i++) send(7, 9, 1023, 0, 0, 1'b0);
        fend();
        wait_valid(1'b0, lat);
        chk("rst_after_lat", lat, 67);
        chk("rst_after_x", int'(bus16.x_obj), 7);
        chk("rst_after_y", int'(bus16.y_obj), 9);
        chk("rst_after_found", int'(bus16.obj_found), 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_block();
        test_below();
        test_enable();
        test_overlap();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
